// File: rtl/fpu_addsub_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : fpu_pkg                                                   |
// | Desc     : Shared types and constants for the add/sub arbiter slice. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fpu_pkg;

  // IEEE-754 single precision, packed {sign, exp, mant}
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float32_t;

  // Substitute result when the adder never reports completion
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } addsub_state_e;

endpackage
`default_nettype wire

// File: rtl/fpu_addsub_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface: fpu_addsub_arbiter_if                                     |
// | Desc     : Requester-side request/response channels of the arbiter.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface fpu_addsub_arbiter_if #(
  parameter int NREQ = 2
);
  import fpu_pkg::*;

  logic     [NREQ-1:0] req_valid;
  logic     [NREQ-1:0] req_ready;
  float32_t [NREQ-1:0] req_a;
  float32_t [NREQ-1:0] req_b;
  logic     [NREQ-1:0] req_op;
  logic     [NREQ-1:0] resp_valid;
  logic     [NREQ-1:0] resp_ready;
  logic     [31:0]     resp_result;
  logic                resp_timeout;

  // Requester group
  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_timeout
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_timeout
  );

endinterface
`default_nettype wire

// File: rtl/fpu_addsub_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arbiter                                                |
// | Desc     : Combinational round-robin pick, searching upward from     |
// |            last_grant+1 and wrapping at NREQ.                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  int   idx;
  logic found;

  // First requester after the previous winner takes the grant
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (en) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = int'(last_grant) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IW'(idx);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_addsub_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fpu_addsub_arbiter                                        |
// | Desc     : Shares one multi-cycle FP add/sub unit between NREQ       |
// |            requesters, with a watchdog for a hung adder.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fpu_addsub_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fpu_addsub_arbiter_if.slave     bus,
  output logic                    busy,
  output logic                    fpu_sign_a,
  output logic [7:0]              fpu_exp_a,
  output logic [22:0]             fpu_mant_a,
  output logic                    fpu_sign_b,
  output logic [7:0]              fpu_exp_b,
  output logic [22:0]             fpu_mant_b,
  output logic                    fpu_op,
  output logic                    fpu_load,
  input  logic                    fpu_sign_out,
  input  logic [7:0]              fpu_exp_out,
  input  logic [22:0]             fpu_mant_out,
  input  logic                    fpu_valid
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  addsub_state_e   state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  float32_t        a_q, a_d;
  float32_t        b_q, b_d;
  logic            op_q, op_d;
  logic [31:0]     result_q, result_d;
  logic            tmo_q, tmo_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            arb_en;

  assign arb_en = (state_q == ST_IDLE);

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Ready is masked while reset is held so nothing looks accepted
  assign bus.req_ready    = grant & {NREQ{rst_n}};
  assign bus.resp_valid   = (state_q == ST_RESP) ? (NREQ'(1) << owner_q) : '0;
  assign bus.resp_result  = result_q;
  assign bus.resp_timeout = tmo_q & (state_q == ST_RESP);

  assign busy       = (state_q != ST_IDLE);
  assign fpu_load   = (state_q == ST_LOAD);
  assign fpu_sign_a = a_q.sign;
  assign fpu_exp_a  = a_q.exp;
  assign fpu_mant_a = a_q.mant;
  assign fpu_sign_b = b_q.sign;
  assign fpu_exp_b  = b_q.exp;
  assign fpu_mant_b = b_q.mant;
  assign fpu_op     = op_q;

  // State and datapath registers; reset drops any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= IW'(NREQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      result_q     <= '0;
      tmo_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state: accept, load, skip one stale-valid cycle, wait, respond
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    tmo_d        = tmo_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          a_d          = bus.req_a[grant_idx];
          b_d          = bus.req_b[grant_idx];
          op_d         = bus.req_op[grant_idx];
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_FLUSH;
      ST_FLUSH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fpu_valid) begin
          result_d = {fpu_sign_out, fpu_exp_out, fpu_mant_out};
          tmo_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          result_d = FP32_QNAN;
          tmo_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fpu_addsub_arbiter                                     |
// | Desc     : Directed self-checking bench with a behavioural adder stub.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_fpu_addsub_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_addsub_arbiter_if #(.NREQ(NREQ)) bus ();

  logic        busy, fpu_sign_a, fpu_sign_b, fpu_op, fpu_load;
  logic [7:0]  fpu_exp_a, fpu_exp_b;
  logic [22:0] fpu_mant_a, fpu_mant_b;
  logic        fpu_sign_out = 1'b0;
  logic [7:0]  fpu_exp_out  = 8'h00;
  logic [22:0] fpu_mant_out = 23'h0;
  logic        fpu_valid    = 1'b0;

  logic [31:0] opa, opb;
  assign opa = {fpu_sign_a, fpu_exp_a, fpu_mant_a};
  assign opb = {fpu_sign_b, fpu_exp_b, fpu_mant_b};

  fpu_addsub_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .busy         (busy),
    .fpu_sign_a   (fpu_sign_a),
    .fpu_exp_a    (fpu_exp_a),
    .fpu_mant_a   (fpu_mant_a),
    .fpu_sign_b   (fpu_sign_b),
    .fpu_exp_b    (fpu_exp_b),
    .fpu_mant_b   (fpu_mant_b),
    .fpu_op       (fpu_op),
    .fpu_load     (fpu_load),
    .fpu_sign_out (fpu_sign_out),
    .fpu_exp_out  (fpu_exp_out),
    .fpu_mant_out (fpu_mant_out),
    .fpu_valid    (fpu_valid)
  );

  // Adder stub: table of hand-computed sums, programmable latency,
  // hang mode, and a mode that leaves the old valid up one extra cycle.
  int          stub_lat   = 2;
  bit          stub_hang  = 1'b0;
  bit          stub_stale = 1'b0;
  logic        st_busy    = 1'b0;
  logic        st_clr     = 1'b0;
  int          st_cnt     = 0;
  logic [31:0] st_res     = 32'h0;

  function automatic logic [31:0] stub_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    case ({a, b, op})
      {32'h3F80_0000, 32'h4000_0000, 1'b0}: return 32'h4040_0000; // 1+2
      {32'h4040_0000, 32'h3F80_0000, 1'b1}: return 32'h4000_0000; // 3-1
      {32'h4000_0000, 32'h4000_0000, 1'b0}: return 32'h4080_0000; // 2+2
      {32'h3F00_0000, 32'h3F00_0000, 1'b0}: return 32'h3F80_0000; // .5+.5
      default:                              return 32'h0BAD_0BAD;
    endcase
  endfunction

  always @(posedge clk) begin
    if (fpu_load) begin
      st_busy <= 1'b1;
      st_cnt  <= stub_lat;
      st_res  <= stub_model(opa, opb, fpu_op);
      if (stub_stale) st_clr <= 1'b1;
      else            fpu_valid <= 1'b0;
    end else begin
      if (st_clr) begin
        fpu_valid <= 1'b0;
        st_clr    <= 1'b0;
      end
      if (st_busy && !stub_hang) begin
        if (st_cnt == 0) begin
          fpu_valid <= 1'b1;
          {fpu_sign_out, fpu_exp_out, fpu_mant_out} <= st_res;
          st_busy <= 1'b0;
        end else begin
          st_cnt <= st_cnt - 1;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge, wait for acceptance, then
  // return at the falling edge inside LOAD with operands scrambled.
  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    int n;
    bus.req_valid[i] = 1'b1;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
    bus.req_op[i]    = op;
    n = 0;
    #1;
    while (!bus.req_ready[i] && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_onehot", bus.req_ready, 32'(1) << i);
    @(negedge clk);
    bus.req_valid[i] = 1'b0;
    bus.req_a[i]     = 32'hFFFF_FFFF;
    bus.req_b[i]     = 32'hFFFF_FFFF;
    bus.req_op[i]    = ~op;
  endtask

  // Count falling edges until a response appears (bounded)
  task automatic wait_resp(output int n, output int loads);
    n = 0;
    loads = 0;
    do begin
      @(negedge clk);
      n++;
      if (fpu_load) loads++;
    end while (bus.resp_valid == '0 && n < 300);
  endtask

  task automatic ack(input int i);
    bus.resp_ready[i] = 1'b1;
    @(negedge clk);
    bus.resp_ready[i] = 1'b0;
    chk("ack_clears_resp", bus.resp_valid, 0);
    chk("ack_idle", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          n, loads, seen;
    logic [1:0]  exp_oh;
    logic [31:0] exp_res;

    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = '0;
    rst_n = 1'b0;

    // Reset state, with requests already pending
    repeat (2) @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load", fpu_load, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_timeout", bus.resp_timeout, 0);
    chk("rst_result", bus.resp_result, 0);
    chk("rst_opa", opa, 0);
    chk("rst_opb", opb, 0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single add from requester 0
    send(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    chk("add_load_high", fpu_load, 1);
    chk("add_busy", busy, 1);
    chk("add_opa", opa, 32'h3F80_0000);
    chk("add_opb", opb, 32'h4000_0000);
    chk("add_op", fpu_op, 0);
    wait_resp(n, loads);
    chk("add_latency", n, 5);
    chk("add_load_once", loads, 0);
    chk("add_resp_owner", bus.resp_valid, 2'b01);
    chk("add_result", bus.resp_result, 32'h4040_0000);
    chk("add_timeout", bus.resp_timeout, 0);
    chk("add_opa_held", opa, 32'h3F80_0000);
    ack(0);

    // Subtract from requester 1
    send(1, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    chk("sub_op", fpu_op, 1);
    wait_resp(n, loads);
    chk("sub_resp_owner", bus.resp_valid, 2'b10);
    chk("sub_result", bus.resp_result, 32'h4000_0000);
    chk("sub_timeout", bus.resp_timeout, 0);
    ack(1);

    // Fairness after a fresh reset: both hold valid for four operations
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.req_a[0] = 32'h4000_0000; bus.req_b[0] = 32'h4000_0000; bus.req_op[0] = 1'b0;
    bus.req_a[1] = 32'h3F00_0000; bus.req_b[1] = 32'h3F00_0000; bus.req_op[1] = 1'b0;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_oh  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_res = (k % 2 == 0) ? 32'h4080_0000 : 32'h3F80_0000;
      n = 0;
      #1;
      while (bus.req_ready == '0 && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("fair_grant", bus.req_ready, exp_oh);
      @(negedge clk);
      chk("fair_no_ready_busy", bus.req_ready, 0);
      wait_resp(n, loads);
      chk("fair_resp_owner", bus.resp_valid, exp_oh);
      chk("fair_result", bus.resp_result, exp_res);
      bus.resp_ready = exp_oh;
      @(negedge clk);
      bus.resp_ready = '0;
    end
    bus.req_valid = '0;
    @(negedge clk);

    // Back-pressure on requester 0 while requester 1 waits
    send(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    bus.req_valid[1] = 1'b1;
    bus.req_a[1] = 32'h4040_0000; bus.req_b[1] = 32'h3F80_0000; bus.req_op[1] = 1'b1;
    wait_resp(n, loads);
    bus.resp_ready = 2'b10;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_resp_valid", bus.resp_valid, 2'b01);
      chk("bp_result", bus.resp_result, 32'h4040_0000);
      chk("bp_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.resp_ready = 2'b01;
    @(negedge clk);
    bus.resp_ready = '0;
    #1;
    chk("bp_next_grant", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    wait_resp(n, loads);
    chk("bp_second_owner", bus.resp_valid, 2'b10);
    chk("bp_second_result", bus.resp_result, 32'h4000_0000);
    ack(1);

    // Watchdog with a hung adder
    stub_hang = 1'b1;
    send(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    wait_resp(n, loads);
    chk("wd_latency", n, 3 + TIMEOUT);
    chk("wd_resp_owner", bus.resp_valid, 2'b01);
    chk("wd_result", bus.resp_result, 32'h7FC0_0000);
    chk("wd_timeout", bus.resp_timeout, 1);
    ack(0);
    chk("wd_timeout_drops", bus.resp_timeout, 0);
    stub_hang = 1'b0;
    send(1, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    wait_resp(n, loads);
    chk("wd_recover_latency", n, 5);
    chk("wd_recover_result", bus.resp_result, 32'h4000_0000);
    chk("wd_recover_timeout", bus.resp_timeout, 0);
    ack(1);

    // Stale valid still high during FLUSH must be ignored
    stub_stale = 1'b1;
    stub_lat   = 0;
    send(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    wait_resp(n, loads);
    chk("stale_latency", n, 3);
    chk("stale_result", bus.resp_result, 32'h4040_0000);
    ack(0);
    stub_stale = 1'b0;
    stub_lat   = 2;

    // Reset asserted mid-WAIT
    stub_hang = 1'b1;
    send(1, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    repeat (4) @(negedge clk);
    bus.req_valid[0] = 1'b1;
    bus.req_a[0] = 32'h3F80_0000; bus.req_b[0] = 32'h4000_0000; bus.req_op[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_load", fpu_load, 0);
    chk("rstw_resp_valid", bus.resp_valid, 0);
    chk("rstw_timeout", bus.resp_timeout, 0);
    chk("rstw_req_ready", bus.req_ready, 0);
    chk("rstw_result", bus.resp_result, 0);
    chk("rstw_opa", opa, 0);
    chk("rstw_op", fpu_op, 0);
    bus.req_valid = '0;
    stub_hang = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.resp_valid != '0 || busy) seen++;
    end
    chk("rstw_no_response", seen, 0);

    // Normal operation after the reset; requester 0 wins first again
    send(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    wait_resp(n, loads);
    chk("post_rst_latency", n, 5);
    chk("post_rst_owner", bus.resp_valid, 2'b01);
    chk("post_rst_result", bus.resp_result, 32'h4040_0000);
    ack(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_addsub_arbiter.md
# fpu_addsub_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle `float_adder_subtractor` instance between `NREQ` requesters. It accepts IEEE-754 single-precision add/subtract requests, drives the adder's `load`/`op`/operand ports, and waits for `valid`. It returns the packed result to the winning requester through a valid/ready response channel. A watchdog recovers from operand combinations for which the adder never asserts `valid`.

## Interface
- `NREQ`, default 2: number of requesters (2..8).
- `TIMEOUT`, default 64: maximum WAIT cycles before the operation is abandoned.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_ready` out NREQ: request accepted this cycle (one-hot or zero).
- `req_a` in NREQ×32: operand A per requester, packed {sign, exp[7:0], mant[22:0]}.
- `req_b` in NREQ×32: operand B per requester, packed the same way.
- `req_op` in NREQ: 0 = A+B, 1 = A−B.
- `resp_valid` out NREQ: result available, one-hot to the request owner.
- `resp_ready` in NREQ: owner takes the result.
- `resp_result` out 32: packed result.
- `resp_timeout` out 1: the result is a watchdog substitute; qualified by `resp_valid`.
- `busy` out 1: state ≠ IDLE.
- `fpu_sign_a`, `fpu_exp_a`, `fpu_mant_a`, `fpu_sign_b`, `fpu_exp_b`, `fpu_mant_b` out 1/8/23 each: adder operands, driven from registers.
- `fpu_op` out 1: adder op.
- `fpu_load` out 1: adder load strobe.
- `fpu_sign_out`, `fpu_exp_out`, `fpu_mant_out` in 1/8/23: adder result.
- `fpu_valid` in 1: adder done.

## Operation
- **FSM states:** IDLE, LOAD, FLUSH, WAIT, RESP.
- **IDLE:**
  - The arbiter selects the first `req_valid[i]` searching upward from `last_grant+1`, wrapping at NREQ.
  - `req_ready[i]=1` for the winner only, combinationally from `req_valid`.
  - On the handshake: register A, B and op, set `owner=i`, set `last_grant=i`, go to LOAD.
- **LOAD:** `fpu_load=1` for exactly one cycle. The operand registers stay stable through RESP. Next state FLUSH.
- **FLUSH:** one cycle; `fpu_valid` is ignored here because it may be stale from the previous operation. Clear the watchdog counter and go to WAIT.
- **WAIT:**
  - If `fpu_valid=1`, register `{fpu_sign_out, fpu_exp_out, fpu_mant_out}` into `resp_result`, set `resp_timeout=0`, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, set `resp_result=32'h7FC00000` (quiet NaN) and `resp_timeout=1`, then go to RESP.
- **RESP:**
  - `resp_valid[owner]=1`; `resp_result` and `resp_timeout` are held.
  - On `resp_ready[owner]`, go to IDLE. `resp_ready` from non-owners is ignored.
- No new request is accepted before the RESP handshake completes (one operation in flight).
- **Recovery after a hung adder:** the next `fpu_load` restarts it, because load has priority inside the adder. No adder reset is needed.
- **Reset values:**
  - All `req_ready`, `resp_valid`, `resp_timeout`, `busy` and `fpu_load` outputs are 0.
  - `resp_result` and the operand registers are 0.
  - `last_grant=NREQ−1`, so requester 0 wins first.
  - State is IDLE.
- **Reset mid-operation:** the FSM is forced to IDLE immediately and the in-flight request is dropped with no response. The requester must reissue it. The adder is not reset.

## Timing
- A request accepted at edge t gives `fpu_load` high in cycle t+1.
- WAIT begins at t+3, so `resp_valid` rises at t+3+k+1, where k is the number of WAIT cycles until `fpu_valid`.
- Timeout path: `resp_valid` rises `TIMEOUT`+1 cycles after WAIT entry.
- Minimum back-to-back spacing is 5 cycles (IDLE, LOAD, FLUSH, WAIT, RESP).
- `req_valid` may drop before `req_ready` without any effect. Once accepted, requester operands may change freely.
- When several requesters are valid in one IDLE cycle, exactly one `req_ready` is asserted.

## Structure
- **Package `fpu_pkg`:**
  - `float32_t` packed struct {sign, exp[7:0], mant[22:0]}.
  - `FP32_QNAN = 32'h7FC00000`.
  - FSM state enum `addsub_state_e`.
- **Sub-module `rr_arbiter`:** parameter NREQ; inputs `req`, `last_grant`, `en`; outputs one-hot `grant` and encoded `grant_idx`. It is purely combinational.
- **Top level:** FSM, operand and result registers, watchdog counter of width clog2(TIMEOUT+1).

## Test plan
- **Single add:** req0 sends A=0x3F800000, B=0x40000000, op=0 → `fpu_load` pulses once at t+1, then `resp_valid[0]` with `resp_result=0x40400000` and `resp_timeout=0`.
- **Subtract:** req1 sends A=0x40400000, B=0x3F800000, op=1 → `resp_valid[1]` with `resp_result=0x40000000`.
- **Fairness:** after reset, both requesters hold `req_valid` for 4 operations → grant order is 0,1,0,1, and `resp_valid` goes only to the matching owner.
- **Watchdog:** an adder stub holds `fpu_valid=0` with TIMEOUT=64 → `resp_valid` rises 65 cycles after WAIT entry, with `resp_result=0x7FC00000` and `resp_timeout=1`. The next request completes normally.
- **Back-pressure:** `resp_ready[0]=0` for 10 cycles → `resp_valid[0]` and `resp_result` are stable, and `req_ready` stays 0 for a pending req1.
- **Reset mid-WAIT, plus stale valid:**
  - `rst_n` low during WAIT → all outputs are 0 immediately, and no response is issued for that request.
  - Separately, `fpu_valid` held high during FLUSH → the sample is ignored, and the result is taken only from WAIT.
